// File: rtl/decoder_scan_seq_pkg.sv
// Shared definitions for the decoder select sequencer: default widths and FSM state encoding.
package decoder_scan_seq_pkg;

    localparam int SEL_W_DEF  = 2;
    localparam int PASS_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_scan_seq_next_code.sv
// Combinational next-code / wrap / first-code generator for the select sweep.
// With SCAN_SKIP_EN defined, masked codes are jumped over and the sweep bounds follow the mask.
module scan_next_code #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      cur_code,
`ifdef SCAN_SKIP_EN
    input  logic [2**SEL_W-1:0]   mask,
`endif
    output logic [SEL_W-1:0]      nxt_code,
    output logic                  wrap,
    output logic [SEL_W-1:0]      first_code,
    output logic                  all_masked
);

    localparam int CODES = 2**SEL_W;

`ifdef SCAN_SKIP_EN
    logic [SEL_W-1:0] last_code_s;

    // Sweep bounds and next unmasked code above the current one, falling back to the first code
    always_comb begin
        first_code  = {SEL_W{1'b0}};
        last_code_s = {SEL_W{1'b0}};
        all_masked  = 1'b1;
        for (int i = 0; i < CODES; i++) begin
            if (!mask[i]) begin
                if (all_masked) begin
                    first_code = SEL_W'(i);
                end else begin
                    first_code = first_code;
                end
                all_masked  = 1'b0;
                last_code_s = SEL_W'(i);
            end else begin
                last_code_s = last_code_s;
            end
        end
        nxt_code = first_code;
        // Walking downward leaves the lowest qualifying code in nxt_code
        for (int i = CODES - 1; i >= 0; i--) begin
            if (!mask[i] && (SEL_W'(i) > cur_code)) begin
                nxt_code = SEL_W'(i);
            end else begin
                nxt_code = nxt_code;
            end
        end
        wrap = (cur_code == last_code_s);
    end
`else
    // Plain sweep: natural binary increment, wrap after the top code
    always_comb begin
        nxt_code   = cur_code + SEL_W'(1);
        wrap       = &cur_code;
        first_code = {SEL_W{1'b0}};
        all_masked = 1'b0;
    end
`endif

endmodule

// File: rtl/decoder_scan_seq.sv
// Select sequencer feeding the 2x4 one-hot decoder: sweeps codes for a programmed pass count
// under a valid/ready handshake. Optional skip mask enabled by SCAN_SKIP_EN.
module decoder_scan_seq
    import decoder_scan_seq_pkg::*;
#(
    parameter int SEL_W  = SEL_W_DEF,
    parameter int PASS_W = PASS_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PASS_W-1:0]   passes,
`ifdef SCAN_SKIP_EN
    input  logic [2**SEL_W-1:0] skip_mask,
`endif
    input  logic                sel_ready,
    output logic                sel_valid,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic                done,
    output logic [PASS_W-1:0]   pass_cnt
);

    localparam int CODES = 2**SEL_W;

    state_t              state_r, state_s;
    logic [SEL_W-1:0]    sel_r, sel_s;
    logic                sel_valid_r, sel_valid_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [PASS_W-1:0]   pass_cnt_r, pass_cnt_s;
    logic [PASS_W-1:0]   passes_r, passes_s;
    logic [PASS_W-1:0]   pass_inc_s;
    logic [SEL_W-1:0]    nxt_code_s;
    logic [SEL_W-1:0]    first_code_s;
    logic                wrap_s;
    logic                all_masked_s;
`ifdef SCAN_SKIP_EN
    logic [CODES-1:0]    mask_r, mask_s;
    logic [CODES-1:0]    mask_use_s;

    // In IDLE the incoming mask decides the first code; during a run the latched one rules
    always_comb begin
        if (state_r == ST_IDLE) begin
            mask_use_s = skip_mask;
        end else begin
            mask_use_s = mask_r;
        end
    end
`endif

    scan_next_code #(
        .SEL_W (SEL_W)
    ) u_next (
        .cur_code   (sel_r),
`ifdef SCAN_SKIP_EN
        .mask       (mask_use_s),
`endif
        .nxt_code   (nxt_code_s),
        .wrap       (wrap_s),
        .first_code (first_code_s),
        .all_masked (all_masked_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        sel_valid_s = sel_valid_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        pass_cnt_s  = pass_cnt_r;
        passes_s    = passes_r;
`ifdef SCAN_SKIP_EN
        mask_s      = mask_r;
`endif
        pass_inc_s  = pass_cnt_r + PASS_W'(1);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    pass_cnt_s = {PASS_W{1'b0}};
                    passes_s   = passes;
`ifdef SCAN_SKIP_EN
                    mask_s     = skip_mask;
`endif
                    if ((passes == {PASS_W{1'b0}}) || all_masked_s) begin
                        state_s     = ST_FIN;
                        sel_valid_s = 1'b0;
                        busy_s      = 1'b0;
                        done_s      = 1'b1;
                    end else begin
                        state_s     = ST_RUN;
                        sel_s       = first_code_s;
                        sel_valid_s = 1'b1;
                        busy_s      = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sel_ready) begin
                    sel_s = nxt_code_s;
                    if (wrap_s) begin
                        pass_cnt_s = pass_inc_s;
                        if (pass_inc_s == passes_r) begin
                            state_s     = ST_FIN;
                            sel_valid_s = 1'b0;
                            busy_s      = 1'b0;
                            done_s      = 1'b1;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIN: begin
                state_s     = ST_IDLE;
                sel_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
            default: begin
                state_s     = ST_IDLE;
                sel_s       = {SEL_W{1'b0}};
                sel_valid_s = 1'b0;
                busy_s      = 1'b0;
                pass_cnt_s  = {PASS_W{1'b0}};
            end
        endcase
    end

    // State and output registers; rst aborts any run without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sel_r       <= {SEL_W{1'b0}};
            sel_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_cnt_r  <= {PASS_W{1'b0}};
            passes_r    <= {PASS_W{1'b0}};
`ifdef SCAN_SKIP_EN
            mask_r      <= {CODES{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            sel_valid_r <= sel_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_cnt_r  <= pass_cnt_s;
            passes_r    <= passes_s;
`ifdef SCAN_SKIP_EN
            mask_r      <= mask_s;
`endif
        end
    end

    assign sel_valid = sel_valid_r;
    assign sel       = sel_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass_cnt  = pass_cnt_r;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq driving a behavioural 2x4 one-hot decoder.
module tb_decoder_scan_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] passes;
    logic       sel_ready;
    logic       sel_valid;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] pass_cnt;
    logic [3:0] dec_o;
`ifdef SCAN_SKIP_EN
    logic [3:0] skip_mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int accept_cnt = 0;
    int done_cnt   = 0;
    logic       held = 1'b0;
    logic [1:0] held_sel = 2'd0;

    always #5 clk = ~clk;

    decoder_scan_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .passes    (passes),
`ifdef SCAN_SKIP_EN
        .skip_mask (skip_mask),
`endif
        .sel_ready (sel_ready),
        .sel_valid (sel_valid),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt)
    );

    // Downstream 2x4 decoder: code n drives output o[n]
    always_comb dec_o = 4'b0001 << sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: handshake stability, decoder one-hot and in-order scoreboard
    always @(negedge clk) begin
        if (rst || !sel_valid) begin
            held = 1'b0;
        end else begin
            chk("onehot", $countones(dec_o), 1);
            chk("dec_bit", dec_o[sel], 1);
            if (held) chk("hold_sel", sel, held_sel);
            if (sel_ready) begin
                held = 1'b0;
                accept_cnt++;
                if (exp_q.size() == 0) chk("sb_extra_code", sel, 99);
                else chk("sb_code", sel, exp_q.pop_front());
            end else begin
                held     = 1'b1;
                held_sel = sel;
            end
        end
        if (!rst && done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_codes(input int p, input logic [3:0] mask);
        for (int k = 0; k < p; k++)
            for (int c = 0; c < 4; c++)
                if (!mask[c]) exp_q.push_back(c);
    endtask

    task automatic do_start(input logic [3:0] p);
        start  = 1'b1;
        passes = p;
        step();
        start  = 1'b0;
        passes = 4'hF;
    endtask

    task automatic run_until_done(input bit toggle, output int busy_cyc);
        logic [3:0] tp;
        bit got;
        tp = 4'b1001;
        got = 1'b0;
        busy_cyc = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) got = 1'b1;
            if (!got) begin
                step();
                if (toggle) sel_ready = tp[(c + 1) % 4];
            end
        end
        chk("done_seen", got, 1);
    endtask

    int bc;
    int acc0;
    int dn0;

    initial begin
        rst = 1'b1; start = 1'b0; passes = 4'd0; sel_ready = 1'b0;
`ifdef SCAN_SKIP_EN
        skip_mask = 4'b0000;
`endif
        step(); step();
        @(negedge clk);
        chk("rst_valid", sel_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        step();
        rst = 1'b0;
        step();

        // Two passes, ready held high
        sel_ready = 1'b1;
        push_codes(2, 4'b0000);
        do_start(4'd2);
        run_until_done(1'b0, bc);
        chk("t2_busy_cycles", bc, 8);
        chk("t2_pass_cnt", pass_cnt, 2);
        chk("t2_valid_at_done", sel_valid, 0);
        chk("t2_sb_empty", exp_q.size(), 0);
        step();
        @(negedge clk);
        chk("t2_done_pulse", done, 0);
        chk("t2_pass_cnt_hold", pass_cnt, 2);
        step();

        // One pass with backpressure pattern 1,0,0,1
        acc0 = accept_cnt;
        push_codes(1, 4'b0000);
        do_start(4'd1);
        run_until_done(1'b1, bc);
        chk("t3_accepts", accept_cnt - acc0, 4);
        chk("t3_sb_empty", exp_q.size(), 0);
        chk("t3_pass_cnt", pass_cnt, 1);
        step();
        sel_ready = 1'b1;
        step();

        // Zero passes: immediate done, no code
        acc0 = accept_cnt;
        do_start(4'd0);
        @(negedge clk);
        chk("t4_done_now", done, 1);
        chk("t4_no_valid", sel_valid, 0);
        step();
        @(negedge clk);
        chk("t4_done_once", done, 0);
        chk("t4_no_accepts", accept_cnt - acc0, 0);
        step();

        // Start during RUN is ignored
        sel_ready = 1'b0;
        push_codes(1, 4'b0000);
        do_start(4'd1);
        step();
        start = 1'b1; passes = 4'd3;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("t4_sel_unmoved", sel, 0);
        step();
        sel_ready = 1'b1;
        run_until_done(1'b0, bc);
        chk("t4_pass_cnt", pass_cnt, 1);
        chk("t4_sb_empty", exp_q.size(), 0);
        step(); step();
        @(negedge clk);
        chk("t4_idle_after", busy, 0);
        step();

        // Reset mid-run after the second accept
        acc0 = accept_cnt;
        push_codes(3, 4'b0000);
        do_start(4'd3);
        step(); step();
        chk("t5_two_accepts", accept_cnt - acc0, 2);
        rst = 1'b1;
        dn0 = done_cnt;
        step();
        exp_q.delete();
        @(negedge clk);
        chk("t5_valid", sel_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_sel", sel, 0);
        chk("t5_pass_cnt", pass_cnt, 0);
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("t5_no_done", done_cnt - dn0, 0);

`ifdef SCAN_SKIP_EN
        // Masked sweep: only codes 1 and 3
        skip_mask = 4'b0101;
        acc0 = accept_cnt;
        push_codes(1, 4'b0101);
        do_start(4'd1);
        skip_mask = 4'b0000;
        run_until_done(1'b0, bc);
        chk("t6_accepts", accept_cnt - acc0, 2);
        chk("t6_busy_cycles", bc, 2);
        chk("t6_sb_empty", exp_q.size(), 0);
        step(); step();
        // Fully masked: straight to done
        skip_mask = 4'b1111;
        acc0 = accept_cnt;
        do_start(4'd2);
        skip_mask = 4'b0000;
        @(negedge clk);
        chk("t6_full_mask_done", done, 1);
        chk("t6_full_mask_valid", sel_valid, 0);
        step(); step();
        chk("t6_full_mask_accepts", accept_cnt - acc0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
